// File: rtl/muldiv_unit_pkg.sv
// Shared types for the multiply/divide unit: RV32M op encoding, FSM states, 32-bit word types.
package muldiv_unit_pkg;

  // Values follow RV32M funct3; bit 2 set means a divide-class op.
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_t;

  typedef logic [31:0]        word_t;
  typedef logic signed [31:0] signed_word_t;

endpackage

// File: rtl/muldiv_step.sv
// One BUSY-cycle radix step, combinational, retiring STEP_BITS bits.
// Divide: restoring, with hi = partial remainder and lo = dividend/quotient. Multiply: shift-add, with {hi,lo} = product/multiplier.
module muldiv_step #(
  parameter int XLEN      = 32,
  parameter int STEP_BITS = 1
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN-1:0] h, l;
  logic [XLEN:0]   r, s;

  always_comb begin
    h = hi;
    l = lo;
    r = '0;
    s = '0;
    for (int i = 0; i < STEP_BITS; i++) begin
      if (is_div) begin
        r = {h, l[XLEN-1]};
        l = {l[XLEN-2:0], 1'b0};
        if (r >= {1'b0, b}) begin
          r    = r - {1'b0, b};
          l[0] = 1'b1;
        end
        h = r[XLEN-1:0];
      end else begin
        s = {1'b0, h} + (l[0] ? {1'b0, b} : '0);
        h = s[XLEN:1];
        l = {s[0], l[XLEN-1:1]};
      end
    end
    hi_nxt = h;
    lo_nxt = l;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M mul/div: latency XLEN/STEP_BITS+1, or 1 for early-outs; holds the result until out_ready; in_ready only in IDLE.
// SARATOGA_FAST_MUL_EN selects a single-cycle combinational multiply in place of the iterative path.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int STEP_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  muldiv_op_t      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int NSTEPS = XLEN / STEP_BITS;
  localparam int CW     = $clog2(NSTEPS + 1);

  muldiv_state_t   state_q, state_d;
  muldiv_op_t      op_q;
  logic [XLEN-1:0] hi_q, lo_q, b_q, hi_nxt, lo_nxt, result_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_q;

  logic            accept, last_step, op_div, op_rem, s1_neg, s2_neg, early;
  logic [XLEN-1:0] src1_mag, src2_mag, early_val, busy_val;

  // Sign fix-up of the full double-width product, then pick low or high half.
  function automatic logic [XLEN-1:0] mul_pick(muldiv_op_t o, logic [2*XLEN-1:0] p, logic n);
    logic [2*XLEN-1:0] f;
    f = n ? -p : p;
    return (o == OP_MUL) ? f[XLEN-1:0] : f[2*XLEN-1:XLEN];
  endfunction

  assign accept    = in_valid && in_ready && !flush;
  assign last_step = (cnt_q == CW'(1));
  assign op_div    = op[2];
  assign op_rem    = op[2] && op[1];

  // MUL treats operands as unsigned: the low half of the product is sign-agnostic.
  always_comb begin
    s1_neg = 1'b0;
    s2_neg = 1'b0;
    case (op)
      OP_MULH, OP_DIV, OP_REM: begin
        s1_neg = src1[XLEN-1];
        s2_neg = src2[XLEN-1];
      end
      OP_MULHSU: s1_neg = src1[XLEN-1];
      default: ;
    endcase
  end

  assign src1_mag = s1_neg ? -src1 : src1;
  assign src2_mag = s2_neg ? -src2 : src2;

`ifdef SARATOGA_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, src1_mag} * {{XLEN{1'b0}}, src2_mag};
`endif

  always_comb begin
    early     = 1'b0;
    early_val = '0;
    if (op_div) begin
      if (src2 == '0) begin
        early     = 1'b1;
        early_val = op_rem ? src1 : '1;
      end else if ((op == OP_DIV || op == OP_REM) &&
                   src1 == {1'b1, {(XLEN-1){1'b0}}} && src2 == '1) begin
        early     = 1'b1;
        early_val = op_rem ? '0 : src1;
      end
    end else begin
`ifdef SARATOGA_FAST_MUL_EN
      early     = 1'b1;
      early_val = mul_pick(op, fast_prod, s1_neg ^ s2_neg);
`else
      if (src1 == '0 || src2 == '0) early = 1'b1;
`endif
    end
  end

  muldiv_step #(.XLEN(XLEN), .STEP_BITS(STEP_BITS)) u_step (
    .is_div (op_q[2]),
    .hi     (hi_q),
    .lo     (lo_q),
    .b      (b_q),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  assign busy_val = !op_q[2] ? mul_pick(op_q, {hi_nxt, lo_nxt}, neg_q) :
                    op_q[1]  ? (neg_q ? -hi_nxt : hi_nxt) :
                               (neg_q ? -lo_nxt : lo_nxt);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = early ? ST_DONE : ST_BUSY;
      ST_BUSY: if (last_step) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_MUL;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else if (!flush) begin
      if (accept) begin
        op_q  <= op;
        hi_q  <= '0;
        cnt_q <= CW'(NSTEPS);
        neg_q <= op_rem ? s1_neg : (s1_neg ^ s2_neg);
        lo_q  <= op_div ? src1_mag : src2_mag;
        b_q   <= op_div ? src2_mag : src1_mag;
        if (early) result_q <= early_val;
      end else if (state_q == ST_BUSY) begin
        hi_q  <= hi_nxt;
        lo_q  <= lo_nxt;
        cnt_q <= cnt_q - CW'(1);
        if (last_step) result_q <= busy_val;
      end
    end
  end

  assign result = result_q;
  assign zero   = (result_q == '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver queues expected results and arrival cycles from a 64-bit arithmetic model.
// A separate monitor checks every cycle that out_valid is high and applies random or directed back-pressure.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  parameter int STEP_BITS = 1;
  localparam int XLEN = 32;
  localparam int N    = XLEN / STEP_BITS;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, out_valid, out_ready, zero;
  muldiv_op_t      op;
  logic [XLEN-1:0] src1, src2, result;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int directed_hold = 0;

  logic [31:0] exp_res_q[$];
  int          exp_cyc_q[$];

  typedef struct {
    muldiv_op_t  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;
  vec_t dir [7];

  muldiv_unit #(.XLEN(XLEN), .STEP_BITS(STEP_BITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_res(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub, p;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (o)
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin pu = {32'h0, a} * {32'h0, b}; return pu[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb;
        return p[31:0];
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb;
        return p[31:0];
      end
      OP_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub;
        return p[31:0];
      end
      OP_REMU: begin
        if (b == 0) return a;
        p = ua % ub;
        return p[31:0];
      end
      default: begin p = sa * sb; return p[31:0]; end
    endcase
  endfunction

  function automatic int exp_lat(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
    if (o inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) begin
      if (b == 0) return 1;
      if (o inside {OP_DIV, OP_REM} && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return N + 1;
    end
`ifdef SARATOGA_FAST_MUL_EN
    return 1;
`else
    if (a == 0 || b == 0) return 1;
    return N + 1;
`endif
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(1, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Returns the latency queued, or 0 if the unit never became ready.
  task automatic issue(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, output int lat);
    int w;
    w = 0;
    lat = 0;
    @(negedge clk);
    op = o;
    src1 = a;
    src2 = b;
    in_valid = 1'b1;
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles, required 1", w);
      in_valid = 1'b0;
      return;
    end
    lat = exp_lat(o, a, b);
    exp_res_q.push_back(exp);
    exp_cyc_q.push_back(cyc + lat);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_res_q.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (exp_res_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_res_q.size());
      exp_res_q.delete();
      exp_cyc_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic flush_now();
    flush = 1'b1;
    void'(exp_res_q.pop_back());
    void'(exp_cyc_q.pop_back());
    @(negedge clk);
    flush = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
  endtask

  // Monitor: checks arrival cycle on first sight, then result/zero/in_ready every held cycle.
  initial begin
    bit seen;
    int held, hold_tgt;
    seen = 0;
    held = 0;
    hold_tgt = 0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !rst) begin
        if (exp_res_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out_valid: result 0x%0h with nothing outstanding", result);
          out_ready = 1'b1;
        end else begin
          if (!seen) begin
            seen = 1;
            held = 0;
            check("latency_cycle", 64'(cyc), 64'(exp_cyc_q[0]));
            if (directed_hold > 0) begin
              hold_tgt = directed_hold;
              directed_hold = 0;
            end else begin
              hold_tgt = $urandom_range(0, 3);
            end
          end
          check("result", result, exp_res_q[0]);
          check("zero", zero, exp_res_q[0] == 0);
          check("in_ready_in_done", in_ready, 0);
          if (held >= hold_tgt) begin
            out_ready = 1'b1;
            void'(exp_res_q.pop_front());
            void'(exp_cyc_q.pop_front());
            seen = 0;
          end else begin
            out_ready = 1'b0;
            held++;
          end
        end
      end else begin
        out_ready = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    muldiv_op_t o;
    logic [31:0] a, b;

    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    op = OP_MUL;
    src1 = '0;
    src2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_zero", zero, 1);

    dir[0] = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    dir[1] = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    dir[2] = '{OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
    dir[3] = '{OP_DIVU,   32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF};
    dir[4] = '{OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
    dir[5] = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    dir[6] = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    for (int i = 0; i < 5; i++) issue(dir[i].o, dir[i].a, dir[i].b, dir[i].r, lat);
    drain();

    // Reset while BUSY on DIV 100/7; the held 0xFFFFFFFF result must be cleared.
    issue(OP_DIV, 32'd100, 32'd7, 32'd14, lat);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_res_q.delete();
    exp_cyc_q.delete();
    check("midbusy_rst_out_valid", out_valid, 0);
    check("midbusy_rst_in_ready", in_ready, 1);
    check("midbusy_rst_result", result, 0);
    check("midbusy_rst_zero", zero, 1);

    for (int i = 5; i < 7; i++) issue(dir[i].o, dir[i].a, dir[i].b, dir[i].r, lat);
    drain();

    // Hold the result for 10 cycles, then a following op must still be accepted.
    directed_hold = 10;
    issue(OP_DIVU, 32'd1000, 32'd10, 32'd100, lat);
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, lat);
    drain();

    // Flush while BUSY; no result may ever appear for the killed op.
    issue(OP_DIVU, 32'd12345, 32'd3, 32'd4115, lat);
    repeat (3) @(negedge clk);
    flush_now();
    repeat (N + 5) @(negedge clk);

    // Flush in the same cycle as in_valid drops the op, even an early-out one.
    op = OP_DIVU;
    src1 = 32'd5;
    src2 = 32'd0;
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
    check("flush_drop_in_ready", in_ready, 1);
    check("flush_drop_out_valid", out_valid, 0);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 80; i++) begin
      o = muldiv_op_t'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      issue(o, a, b, ref_res(o, a, b), lat);
      if (lat > 3 && $urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(1, lat - 3)) @(negedge clk);
        flush_now();
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
